instruction_prefetch_unit: RTL and testbench

INSTRUCTION_PREFETCH_UNIT -- requirements
Module: instruction_prefetch_unit

---
 rtl/instruction_prefetch_unit.sv | 136 +++++++++++++
 tb/tb_instruction_prefetch_unit.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_prefetch_unit.sv
// Instruction prefetch unit: local instruction memory feeding a small {pc, instruction} queue,
// with load mode, redirect (jump) handling and halt-word detection.
module instruction_prefetch_unit #(
    parameter int                LENGTH     = 32,
    parameter int                MEM_DEPTH  = 256,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [LENGTH-1:0] HALT_WORD  = 32'hFFFF_FFFF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          mips_enable,
    input  logic                          wr_memory_instruction_enable,
    input  logic [LENGTH-1:0]             instruction_to_write,
    input  logic [LENGTH-1:0]             address_to_write,
    input  logic                          jump,
    input  logic [LENGTH-1:0]             pc_with_jump,
    input  logic                          instr_ready,
    output logic                          instr_valid,
    output logic [LENGTH-1:0]             program_counter,
    output logic [LENGTH-1:0]             instruction,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          halted
);

    localparam int AW = $clog2(MEM_DEPTH);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0]     FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0]     ONE_C    = CW'(1);
    localparam logic [PW-1:0]     ONE_P    = PW'(1);
    localparam logic [LENGTH-1:0] PC_STEP  = LENGTH'(4);

    typedef enum logic [1:0] {ST_LOAD, ST_FETCH, ST_HALTED} state_t;

    state_t              state_q, state_d;
    logic [LENGTH-1:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]       count_q, count_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;

    logic [LENGTH-1:0]   mem_q     [MEM_DEPTH];
    logic [LENGTH-1:0]   q_pc_q    [FIFO_DEPTH];
    logic [LENGTH-1:0]   q_instr_q [FIFO_DEPTH];

    logic [LENGTH-1:0]   mem_rdata;
    logic                jump_take;
    logic                push;
    logic                pop;
    logic                unused_addr_bits;

    assign unused_addr_bits = ^{address_to_write[LENGTH-1:AW+2], address_to_write[1:0],
                                pc_with_jump[1:0]};

    // Word index keeps only the low AW bits, so fetches wrap around the memory.
    assign mem_rdata = mem_q[fetch_pc_q[AW+1:2]];

    assign instr_valid = (count_q != '0);
    assign jump_take   = mips_enable && jump && (state_q != ST_LOAD);
    assign pop         = instr_valid && instr_ready && mips_enable && !jump_take;
    assign push        = mips_enable && (state_q == ST_FETCH) && !jump_take &&
                         ((count_q != FULL_CNT) || pop);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        if (!mips_enable) begin
            state_d = ST_LOAD;
        end else if (jump_take) begin
            state_d    = ST_FETCH;
            fetch_pc_d = {pc_with_jump[LENGTH-1:2], 2'b00};
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            if (state_q == ST_LOAD) begin
                state_d = ST_FETCH;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + ONE_P;
                // The halt word is queued like any other, but fetching stops on it.
                if (mem_rdata == HALT_WORD) begin
                    state_d = ST_HALTED;
                end else begin
                    fetch_pc_d = fetch_pc_q + PC_STEP;
                end
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + ONE_P;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + ONE_C;
                2'b01:   count_d = count_q - ONE_C;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_LOAD;
            fetch_pc_q <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Storage arrays carry no reset; validity is tracked by the occupancy counter.
    always_ff @(posedge clk) begin
        if (!mips_enable && wr_memory_instruction_enable) begin
            mem_q[address_to_write[AW+1:2]] <= instruction_to_write;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_pc_q[wr_ptr_q]    <= fetch_pc_q;
            q_instr_q[wr_ptr_q] <= mem_rdata;
        end
    end

    assign program_counter = instr_valid ? q_pc_q[rd_ptr_q]    : '0;
    assign instruction     = instr_valid ? q_instr_q[rd_ptr_q] : '0;
    assign fifo_count      = count_q;
    assign halted          = (state_q == ST_HALTED);

endmodule

// File: tb/tb_instruction_prefetch_unit.sv
// Self-checking bench for instruction_prefetch_unit: vector table for the basic program,
// scoreboard queue for delivered {pc, instruction} pairs, directed corner-case sequences.
module tb_instruction_prefetch_unit;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        clk;
    logic        reset;
    logic        mips_enable;
    logic        wr_en;
    logic [31:0] wr_data;
    logic [31:0] wr_addr;
    logic        jump;
    logic [31:0] pc_with_jump;
    logic        instr_ready;
    logic        instr_valid;
    logic [31:0] program_counter;
    logic [31:0] instruction;
    logic [2:0]  fifo_count;
    logic        halted;

    instruction_prefetch_unit dut (
        .clk                          (clk),
        .reset                        (reset),
        .mips_enable                  (mips_enable),
        .wr_memory_instruction_enable (wr_en),
        .instruction_to_write         (wr_data),
        .address_to_write             (wr_addr),
        .jump                         (jump),
        .pc_with_jump                 (pc_with_jump),
        .instr_ready                  (instr_ready),
        .instr_valid                  (instr_valid),
        .program_counter              (program_counter),
        .instruction                  (instruction),
        .fifo_count                   (fifo_count),
        .halted                       (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] wr_addr;
        logic [31:0] wr_data;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    vec_t        vecs [5];
    exp_t        sb [$];
    logic [31:0] mdl_mem [256];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_mem(input logic [31:0] addr, input logic [31:0] data);
        mips_enable = 1'b0;
        wr_en       = 1'b1;
        wr_addr     = addr;
        wr_data     = data;
        step();
        wr_en       = 1'b0;
        mdl_mem[addr[9:2]] = data;
    endtask

    task automatic reset_pulse();
        mips_enable = 1'b0;
        reset       = 1'b0;
        step();
        reset       = 1'b1;
    endtask

    task automatic expect_word(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = mdl_mem[pc[9:2]];
        sb.push_back(e);
    endtask

    task automatic wait_count(input logic [2:0] target, input int budget, input string tag);
        int cyc;
        for (cyc = 0; cyc < budget && fifo_count != target; cyc++) step();
        check({tag, "_count_reached"}, 32'(fifo_count), 32'(target));
    endtask

    // Compares the head against the scoreboard each cycle; with instr_ready=1 each
    // observed head is consumed at the following edge.
    task automatic drain(input int budget, input string tag);
        exp_t e;
        int   n     = sb.size();
        int   first = -1;
        int   last  = -1;
        for (int cyc = 0; cyc < budget && sb.size() > 0; cyc++) begin
            if (instr_valid) begin
                e = sb.pop_front();
                check({tag, "_pc"},    program_counter, e.pc);
                check({tag, "_instr"}, instruction,     e.instr);
                if (first < 0) first = cyc;
                last = cyc;
            end
            if (sb.size() > 0) step();
        end
        if (sb.size() != 0) begin
            check({tag, "_timeout_left"}, 32'(sb.size()), 32'd0);
            sb.delete();
        end else begin
            check({tag, "_one_per_cycle"}, 32'(last - first), 32'(n - 1));
        end
    endtask

    initial begin
        int cnt_before;

        vecs[0] = '{32'd0,  32'h11, 32'd0,  32'h11};
        vecs[1] = '{32'd4,  32'h22, 32'd4,  32'h22};
        vecs[2] = '{32'd8,  32'h33, 32'd8,  32'h33};
        vecs[3] = '{32'd12, 32'h44, 32'd12, 32'h44};
        vecs[4] = '{32'd16, 32'h55, 32'd16, 32'h55};

        reset        = 1'b0;
        mips_enable  = 1'b0;
        wr_en        = 1'b0;
        wr_data      = '0;
        wr_addr      = '0;
        jump         = 1'b0;
        pc_with_jump = '0;
        instr_ready  = 1'b0;

        #3;
        check("rst_valid",  32'(instr_valid), 32'd0);
        check("rst_count",  32'(fifo_count),  32'd0);
        check("rst_halted", 32'(halted),      32'd0);
        check("rst_pc",     program_counter,  32'd0);
        check("rst_instr",  instruction,      32'd0);
        step();
        step();
        reset = 1'b1;

        // Fill memory with non-halt words, then the program from the table.
        for (int i = 0; i < 256; i++) write_mem(32'(i * 4), 32'hA000_0000 + 32'(i));
        for (int i = 0; i < 5; i++) write_mem(vecs[i].wr_addr, vecs[i].wr_data);
        check("load_no_push", 32'(fifo_count), 32'd0);

        // Straight-line program, one instruction per cycle.
        mips_enable = 1'b1;
        instr_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_t e;
            e.pc    = vecs[i].exp_pc;
            e.instr = vecs[i].exp_instr;
            sb.push_back(e);
        end
        drain(30, "seq");

        // Back-pressure: queue saturates, fetch stops at 16, resumes in order.
        reset_pulse();
        mips_enable = 1'b1;
        instr_ready = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("full_count", 32'(fifo_count), 32'd4);
        check("full_valid", 32'(instr_valid), 32'd1);
        check("full_head_pc", program_counter, 32'd0);
        instr_ready = 1'b1;
        for (int i = 0; i < 6; i++) expect_word(32'(i * 4));
        drain(30, "resume");

        // Jump with three entries queued; jump wins over the concurrent pop.
        reset_pulse();
        mips_enable = 1'b1;
        instr_ready = 1'b0;
        wait_count(3'd3, 20, "pre_jump");
        jump         = 1'b1;
        pc_with_jump = 32'h0000_0042;
        instr_ready  = 1'b1;
        step();
        jump        = 1'b0;
        instr_ready = 1'b0;
        check("jump_flush_count", 32'(fifo_count),  32'd0);
        check("jump_flush_valid", 32'(instr_valid), 32'd0);
        step();
        check("jump_head_valid", 32'(instr_valid), 32'd1);
        check("jump_head_pc",    program_counter,  32'h40);
        check("jump_head_instr", instruction,      mdl_mem[16]);
        step();

        // Memory write in load mode leaves the queue untouched; plant the halt word.
        cnt_before = 32'(fifo_count);
        write_mem(32'd8, HALT);
        check("load_write_hold", 32'(fifo_count), 32'(cnt_before));

        reset_pulse();
        mips_enable = 1'b1;
        instr_ready = 1'b1;
        expect_word(32'd0);
        expect_word(32'd4);
        expect_word(32'd8);
        drain(30, "halt");
        step();
        step();
        check("halted_flag",  32'(halted),     32'd1);
        check("halted_empty", 32'(fifo_count), 32'd0);

        jump         = 1'b1;
        pc_with_jump = 32'd0;
        step();
        jump = 1'b0;
        check("unhalt_flag", 32'(halted), 32'd0);
        expect_word(32'd0);
        expect_word(32'd4);
        expect_word(32'd8);
        drain(30, "restart");
        step();
        step();
        check("rehalted_flag", 32'(halted), 32'd1);

        // Wrap past the end of memory: pc 1024 reads word 0.
        jump         = 1'b1;
        pc_with_jump = 32'h3FC;
        step();
        jump = 1'b0;
        begin
            exp_t e;
            e.pc = 32'h3FC; e.instr = mdl_mem[255]; sb.push_back(e);
            e.pc = 32'h400; e.instr = mdl_mem[0];   sb.push_back(e);
            e.pc = 32'h404; e.instr = mdl_mem[1];   sb.push_back(e);
            e.pc = 32'h408; e.instr = mdl_mem[2];   sb.push_back(e);
        end
        drain(30, "wrap");
        step();

        // Async reset with a full queue; writes while running are ignored.
        write_mem(32'd8, 32'h33);
        reset_pulse();
        mips_enable = 1'b1;
        instr_ready = 1'b0;
        wr_en       = 1'b1;
        wr_addr     = 32'd0;
        wr_data     = 32'hDEAD_BEEF;
        wait_count(3'd4, 20, "pre_reset");
        wr_en = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_valid", 32'(instr_valid), 32'd0);
        check("async_rst_count", 32'(fifo_count),  32'd0);
        check("async_rst_pc",    program_counter,  32'd0);
        check("async_rst_instr", instruction,      32'd0);
        step();
        mips_enable = 1'b0;
        reset       = 1'b1;
        step();
        mips_enable = 1'b1;
        instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) expect_word(32'(i * 4));
        drain(30, "preserved");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
